shifter_operand_stage: RTL
==========================

// Module: shifter_operand_stage
// PURPOSE
//  Operand stage directly upstream of the 32-bit ALU. Accepts a decoded ARM data-processing instruction
//  plus Rn/Rm register values and computes the shifter operand and shifter carry-out. Covers immediate-rotate,
//  immediate-shift and register-shift forms. Results are registered into the ALU input slot behind a
//  valid/ready handshake. Register-specified shifts take one extra cycle, to read Rs over a shared register-file port.
// PARAMETERS
//  WIDTH  32  datapath width; must equal `FULLW
// PORTS
//  clk                 in   1      single clock, rising edge
//  nreset              in   1      asynchronous, active-low reset
//  flush               in   1      synchronous kill of in-flight op and output slot
//  in_valid            in   1      instr/rn_val/rm_val valid
//  in_ready            out  1      stage can accept this cycle
//  instr               in   32     data-processing instruction word
//  rn_val, rm_val      in   WIDTH  Rn / Rm register contents
//  cflag_in            in   1      current CPSR C flag
//  rs_req              out  1      Rs read-port request
//  rs_addr             out  4      Rs index (instr[11:8] of held op)
//  rs_val              in   WIDTH  Rs contents, async read, valid in the cycle rs_req=1
//  out_valid           out  1      ALU operand slot holds valid data
//  out_ready           in   1      ALU stage consumes slot this cycle
//  alu_opcode          out  4      instr[24:21] pass-through
//  alu_setflags        out  1      instr[20] pass-through
//  alu_rd              out  4      instr[15:12] pass-through
//  alu_rn              out  WIDTH  latched Rn
//  alu_shifter         out  WIDTH  shifter operand
//  alu_shiftercarryout out  1      shifter carry-out
// BEHAVIOUR
//  Reset (nreset=0, async): state=IDLE; out_valid=0; rs_req=0; rs_addr=0; all alu_* outputs=0.
//  in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Accept = in_valid && in_ready.
//  FSM IDLE:
//   - accept, and the op is imm-rotate or imm-shift: compute and load the slot; out_valid=1 next cycle (latency 1).
//   - accept, and the op is reg-shift (I=0, instr[4]=1): latch instr/rn_val/rm_val, go to RS_FETCH;
//     the slot is not loaded (out_valid goes 0 if the slot was drained).
//  FSM RS_FETCH: rs_req=1, rs_addr=instr[11:8]; amt=rs_val[7:0]; compute, load the slot, go to IDLE
//   (latency 2). The slot is guaranteed empty here.
//  Slot update: out_ready && out_valid with no new load -> out_valid=0. Unaccepted slot holds all outputs stable.
//  flush: wins over accept/load; out_valid=0, state=IDLE, rs_req=0 next cycle. Mid-RS_FETCH flush drops the op.
//  cflag_in is sampled in the compute cycle (the accept cycle, or the RS_FETCH cycle).
//  Imm-rotate (I=1): imm8=instr[7:0], rot=2*instr[11:8].
//   - shifter = imm8 ROR rot.
//   - carry = (rot==0) ? cflag_in : shifter[31].
//  Imm-shift (I=0, instr[4]=0): amt=instr[11:7], type=instr[6:5]. Results per type:
//   - LSL: #0 -> Rm, C=cflag_in; else Rm<<amt, C=Rm[32-amt].
//   - LSR: #0 means 32 -> 0, C=Rm[31]; else Rm>>amt, C=Rm[amt-1].
//   - ASR: #0 means 32 -> {32{Rm[31]}}, C=Rm[31]; else arithmetic shift, C=Rm[amt-1].
//   - ROR: #0 is RRX -> {cflag_in,Rm[31:1]}, C=Rm[0]; else Rm ROR amt, C=Rm[amt-1].
//  Reg-shift, amt=rs_val[7:0]:
//   - amt==0: Rm, C=cflag_in, for every type.
//   - LSL: 1..31 normal; 32 -> 0, C=Rm[0]; >32 -> 0, C=0.
//   - LSR: 1..31 normal; 32 -> 0, C=Rm[31]; >32 -> 0, C=0.
//   - ASR: >=32 -> {32{Rm[31]}}, C=Rm[31].
//   - ROR: amt[4:0]==0 -> Rm, C=Rm[31]; else Rm ROR amt[4:0], C=result[31].
//  Widths: all arithmetic is in WIDTH bits. amt>=WIDTH must never index out of range (clamp explicitly).
// TESTING
//  1) instr=0x E3A004FF (MOV imm 0xFF ror 8), cflag_in=0 -> next cycle out_valid=1, alu_shifter=0xFF000000, carry=1.
//  2) Imm-shift sweep, Rm=0x80000001:
//     - LSR #0 -> shifter 0, C=1.
//     - ASR #0 -> 0xFFFFFFFF, C=1.
//     - ROR #0 with cflag_in=1 -> 0xC0000000, C=1.
//     - LSL #0 with cflag_in=0 -> 0x80000001, C=0.
//  3) Reg-shift LSL, Rm=0x00000003, rs_val=32 then 33, then LSR rs_val=0 with cflag_in=1:
//     - rs_req=1 in cycle N+1; results 0/C=1, then 0/C=0, then Rm/C=1; out_valid at N+2.
//  4) out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> back-to-back accept, one op/cycle.
//  5) flush in RS_FETCH -> no output for that op, in_ready=1 next cycle; nreset low mid-op -> all outputs 0 immediately.
//  6) Random compare vs reference model of ARM shifter rules: 10k ops with random stalls; checks results and ordering.

Source files
------------

// File: rtl/shifter_operand_stage_if.sv
// Bus bundle for the shifter operand stage.
//   Input side : in_valid/in_ready handshake carrying instr, rn_val, rm_val, cflag_in.
//   Rs port    : rs_req/rs_addr out, rs_val back (asynchronous read, same cycle).
//   Output side: out_valid/out_ready handshake carrying the alu_* operand slot.
// Handshake rule for both sides: a transfer happens on a rising clk edge where
// valid && ready are both 1. A producer holding valid=1 keeps its payload
// stable until that edge. A consumer may drop ready at any time.
// Modports: slave = the operand stage itself, master = its environment
// (decode/regfile upstream, ALU downstream).
interface shifter_operand_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [WIDTH-1:0] rn_val;
  logic [WIDTH-1:0] rm_val;
  logic             cflag_in;
  logic             rs_req;
  logic [3:0]       rs_addr;
  logic [WIDTH-1:0] rs_val;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_opcode;
  logic             alu_setflags;
  logic [3:0]       alu_rd;
  logic [WIDTH-1:0] alu_rn;
  logic [WIDTH-1:0] alu_shifter;
  logic             alu_shiftercarryout;

  modport slave (
    input  in_valid, instr, rn_val, rm_val, cflag_in, rs_val, out_ready,
    output in_ready, rs_req, rs_addr, out_valid, alu_opcode, alu_setflags,
           alu_rd, alu_rn, alu_shifter, alu_shiftercarryout
  );

  modport master (
    output in_valid, instr, rn_val, rm_val, cflag_in, rs_val, out_ready,
    input  in_ready, rs_req, rs_addr, out_valid, alu_opcode, alu_setflags,
           alu_rd, alu_rn, alu_shifter, alu_shiftercarryout
  );
endinterface

// File: rtl/shifter_operand_stage.sv
// Operand stage in front of the 32-bit ALU. Takes a decoded ARM data-processing
// instruction with Rn/Rm values and produces the shifter operand and carry-out
// into a registered ALU operand slot. Immediate forms complete in one cycle;
// register-specified shifts spend an extra cycle (RS_FETCH) reading Rs.
// Ports:
//   clk       rising-edge clock
//   nreset    asynchronous active-low reset
//   flush     synchronous kill of the in-flight op and the output slot
//   bus       slave view of shifter_operand_stage_if (handshakes, Rs port, ALU slot)
//   dbg_state current FSM state (0 = IDLE, 1 = RS_FETCH)
module shifter_operand_stage #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   flush,
  shifter_operand_stage_if.slave bus,
  output logic [0:0]             dbg_state
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] RS_FETCH = 1'b1;

  logic [0:0]       state;
  logic [31:0]      hold_instr;
  logic [WIDTH-1:0] hold_rn;
  logic [WIDTH-1:0] hold_rm;

  logic [31:0]      cur_instr;
  logic [WIDTH-1:0] cur_rn;
  logic [WIDTH-1:0] cur_rm;
  logic             accept;
  logic             in_is_reg;
  logic             load;
  logic [WIDTH-1:0] sh;
  logic             co;
  logic [4:0]       imm_amt;
  logic [4:0]       rot;
  logic [1:0]       typ;
  logic [7:0]       reg_amt;

  // Rotate right via a doubled word, so a rotate of 0 needs no special case.
  function automatic logic [WIDTH-1:0] ror_w(input logic [WIDTH-1:0] x, input logic [4:0] r);
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} >> r;
    return dbl[WIDTH-1:0];
  endfunction

  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_is_reg    = !bus.instr[25] && bus.instr[4];
  // In RS_FETCH the slot is empty by construction, so it can always load.
  assign load         = !flush && ((accept && !in_is_reg) || (state == RS_FETCH));

  assign bus.rs_req  = (state == RS_FETCH);
  assign bus.rs_addr = (state == RS_FETCH) ? hold_instr[11:8] : 4'h0;
  assign dbg_state   = state;

  // The compute cycle uses live inputs in IDLE and the held op in RS_FETCH.
  assign cur_instr = (state == RS_FETCH) ? hold_instr : bus.instr;
  assign cur_rn    = (state == RS_FETCH) ? hold_rn    : bus.rn_val;
  assign cur_rm    = (state == RS_FETCH) ? hold_rm    : bus.rm_val;

  always_comb begin
    imm_amt = cur_instr[11:7];
    typ     = cur_instr[6:5];
    rot     = {cur_instr[11:8], 1'b0};
    reg_amt = bus.rs_val[7:0];
    sh      = cur_rm;
    co      = bus.cflag_in;
    if (cur_instr[25]) begin
      sh = ror_w({{(WIDTH-8){1'b0}}, cur_instr[7:0]}, rot);
      co = (rot == 5'd0) ? bus.cflag_in : sh[WIDTH-1];
    end else if (!cur_instr[4]) begin
      // Immediate shift: an encoded amount of 0 has a per-type meaning.
      case (typ)
        2'b00: begin
          if (imm_amt != 5'd0) begin
            sh = cur_rm << imm_amt;
            co = cur_rm[5'd0 - imm_amt];
          end
        end
        2'b01: begin
          sh = (imm_amt == 5'd0) ? '0 : (cur_rm >> imm_amt);
          co = (imm_amt == 5'd0) ? cur_rm[WIDTH-1] : cur_rm[imm_amt - 5'd1];
        end
        2'b10: begin
          sh = (imm_amt == 5'd0) ? {WIDTH{cur_rm[WIDTH-1]}} : $unsigned($signed(cur_rm) >>> imm_amt);
          co = (imm_amt == 5'd0) ? cur_rm[WIDTH-1] : cur_rm[imm_amt - 5'd1];
        end
        default: begin
          sh = (imm_amt == 5'd0) ? {bus.cflag_in, cur_rm[WIDTH-1:1]} : ror_w(cur_rm, imm_amt);
          co = (imm_amt == 5'd0) ? cur_rm[0] : cur_rm[imm_amt - 5'd1];
        end
      endcase
    end else if (reg_amt != 8'd0) begin
      // Register shift: amounts of 32 and above are clamped explicitly so no
      // bit index ever leaves the word.
      case (typ)
        2'b00: begin
          if (reg_amt < 8'd32) begin
            sh = cur_rm << reg_amt[4:0];
            co = cur_rm[5'd0 - reg_amt[4:0]];
          end else begin
            sh = '0;
            co = (reg_amt == 8'd32) ? cur_rm[0] : 1'b0;
          end
        end
        2'b01: begin
          if (reg_amt < 8'd32) begin
            sh = cur_rm >> reg_amt[4:0];
            co = cur_rm[reg_amt[4:0] - 5'd1];
          end else begin
            sh = '0;
            co = (reg_amt == 8'd32) ? cur_rm[WIDTH-1] : 1'b0;
          end
        end
        2'b10: begin
          if (reg_amt < 8'd32) begin
            sh = $unsigned($signed(cur_rm) >>> reg_amt[4:0]);
            co = cur_rm[reg_amt[4:0] - 5'd1];
          end else begin
            sh = {WIDTH{cur_rm[WIDTH-1]}};
            co = cur_rm[WIDTH-1];
          end
        end
        default: begin
          sh = ror_w(cur_rm, reg_amt[4:0]);
          co = sh[WIDTH-1];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state                   <= IDLE;
      hold_instr              <= '0;
      hold_rn                 <= '0;
      hold_rm                 <= '0;
      bus.out_valid           <= 1'b0;
      bus.alu_opcode          <= '0;
      bus.alu_setflags        <= 1'b0;
      bus.alu_rd              <= '0;
      bus.alu_rn              <= '0;
      bus.alu_shifter         <= '0;
      bus.alu_shiftercarryout <= 1'b0;
    end else if (flush) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
    end else begin
      if (state == RS_FETCH) begin
        state <= IDLE;
      end else if (accept && in_is_reg) begin
        state <= RS_FETCH;
      end
      if (accept) begin
        hold_instr <= bus.instr;
        hold_rn    <= bus.rn_val;
        hold_rm    <= bus.rm_val;
      end
      if (load) begin
        bus.out_valid           <= 1'b1;
        bus.alu_opcode          <= cur_instr[24:21];
        bus.alu_setflags        <= cur_instr[20];
        bus.alu_rd              <= cur_instr[15:12];
        bus.alu_rn              <= cur_rn;
        bus.alu_shifter         <= sh;
        bus.alu_shiftercarryout <= co;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  // Instruction fields and Rs bits that play no part in the operand.
  logic unused_bits;
  assign unused_bits = ^{cur_instr[31:26], cur_instr[19:16], cur_instr[3:0], bus.rs_val[WIDTH-1:8]};

endmodule
